// File: rtl/arm_enc_pkg.sv
// arm_enc_pkg: shared kinds, ALU command codes, FSM states and error codes for instr_encoder
package arm_enc_pkg;
  typedef enum logic [2:0] {K_DP_IMM, K_DP_REG, K_LDR, K_STR, K_B, K_BL} kind_t;
  typedef enum logic [2:0] {S_IDLE, S_ENC, S_WR, S_ERR, S_FULL} state_t;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_BRANCH = 2'b10;
endpackage

// File: rtl/instr_word_pack.sv
// instr_word_pack: packs registered fields at addr into a 32-bit ARM word; flags illegal kind/cmd and bad branch offsets
module instr_word_pack
  import arm_enc_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [3:0]  cmd,
  input  logic        s,
  input  logic [3:0]  cond,
  input  logic [3:0]  rd,
  input  logic [3:0]  rn,
  input  logic [3:0]  rm,
  input  logic [11:0] imm12,
  input  logic [31:0] target,
  input  logic [31:0] addr,
  output logic [31:0] word,
  output logic        illegal,
  output logic        br_bad
);
  logic [31:0] off;
  logic is_dp, is_mem, is_br, is_imm, cmd_ok;
  assign off = target - (addr + 32'd8);
  assign is_imm = kind == K_DP_IMM;
  assign is_dp = is_imm || kind == K_DP_REG;
  assign is_mem = kind == K_LDR || kind == K_STR;
  assign is_br = kind == K_B || kind == K_BL;
  assign cmd_ok = cmd inside {CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR};
  assign illegal = kind > K_BL || (is_dp && !cmd_ok);
  assign br_bad = is_br && ((|off[1:0]) || !((&off[31:25]) || !(|off[31:25])));
  assign word = is_dp ? {cond, 2'b00, is_imm, cmd, s, rn, rd, is_imm ? imm12 : {8'h0, rm}} :
                is_mem ? {cond, 2'b01, 5'b01100, kind == K_LDR, rn, rd, imm12} :
                {cond, 3'b101, kind == K_BL, off[25:2]};
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts instruction fields via in_valid/in_ready, encodes them and writes words to imem (mem_*), tracking count/full/err
module instr_encoder
  import arm_enc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_kind,
  input  logic [3:0]                 in_cmd,
  input  logic                       in_s,
  input  logic [3:0]                 in_cond,
  input  logic [3:0]                 in_rd,
  input  logic [3:0]                 in_rn,
  input  logic [3:0]                 in_rm,
  input  logic [11:0]                in_imm12,
  input  logic [31:0]                in_target,
  output logic                       mem_we,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       err,
  output logic [1:0]                 err_code
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  state_t state;
  logic [2:0] kind;
  logic [3:0] cmd, cond, rd, rn, rm;
  logic s, illegal, br_bad;
  logic [11:0] imm12;
  logic [31:0] target, addr, word;
  instr_word_pack u_pack (
    .kind(kind), .cmd(cmd), .s(s), .cond(cond), .rd(rd), .rn(rn), .rm(rm),
    .imm12(imm12), .target(target), .addr(addr),
    .word(word), .illegal(illegal), .br_bad(br_bad)
  );
  assign in_ready = state == S_IDLE && !reset;
  // start/reset in the write cycle abort the word before the memory sees it
  assign mem_we = state == S_WR && !reset && !start;
  assign mem_addr = addr;
  assign full = count == DEPTH_C;
  always_ff @(posedge clk) begin
    if (reset || start) begin
      state <= S_IDLE;
      addr <= BASE_ADDR;
      count <= '0;
      err <= 1'b0;
      err_code <= ERR_NONE;
      if (reset) mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          kind <= in_kind;
          cmd <= in_cmd;
          s <= in_s;
          cond <= in_cond;
          rd <= in_rd;
          rn <= in_rn;
          rm <= in_rm;
          imm12 <= in_imm12;
          target <= in_target;
          state <= S_ENC;
        end
        S_ENC: if (illegal || br_bad) begin
          err <= 1'b1;
          err_code <= illegal ? ERR_ILLEGAL : ERR_BRANCH;
          state <= S_ERR;
        end else begin
          mem_wdata <= word;
          state <= S_WR;
        end
        S_WR: begin
          addr <= addr + 32'd4;
          count <= full ? count : count + CW'(1);
          state <= count + CW'(1) == DEPTH_C ? S_FULL : S_IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule
